// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment display mux: active-low segment patterns
// ({g,f,e,d,c,b,a}) and counter width helpers.
package seven_seg_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned SEG_W   = 7;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    localparam logic [SEG_W-1:0] SEG_0 = 7'h40;
    localparam logic [SEG_W-1:0] SEG_1 = 7'h79;
    localparam logic [SEG_W-1:0] SEG_2 = 7'h24;
    localparam logic [SEG_W-1:0] SEG_3 = 7'h30;
    localparam logic [SEG_W-1:0] SEG_4 = 7'h19;
    localparam logic [SEG_W-1:0] SEG_5 = 7'h12;
    localparam logic [SEG_W-1:0] SEG_6 = 7'h02;
    localparam logic [SEG_W-1:0] SEG_7 = 7'h78;
    localparam logic [SEG_W-1:0] SEG_8 = 7'h00;
    localparam logic [SEG_W-1:0] SEG_9 = 7'h10;
    localparam logic [SEG_W-1:0] SEG_A = 7'h08;
    localparam logic [SEG_W-1:0] SEG_B = 7'h03;
    localparam logic [SEG_W-1:0] SEG_C = 7'h46;
    localparam logic [SEG_W-1:0] SEG_D = 7'h21;
    localparam logic [SEG_W-1:0] SEG_E = 7'h06;
    localparam logic [SEG_W-1:0] SEG_F = 7'h0E;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int unsigned pre_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned idx_width(input int unsigned digits);
        return pre_width(digits);
    endfunction

endpackage

// File: rtl/seven_seg_hex_decoder.sv
// Combinational 4-bit hex to active-low seven-segment pattern map.
module seven_seg_hex_decoder
    import seven_seg_pkg::*;
(
    input  logic [DIGIT_W-1:0] hex,
    output logic [SEG_W-1:0]   seg
);

    always_comb begin
        seg = SEG_BLANK;
        unique case (hex)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
        endcase
    end

endmodule

// File: rtl/seven_seg_mux_n.sv
// N-digit time-multiplexed common-anode seven-segment driver with double-buffered digit data.
// Blink support is built only when SEVEN_SEG_BLINK_EN is defined.
module seven_seg_mux_n
    import seven_seg_pkg::*;
#(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLINK_HALF  = 25000000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DIGIT_W*DIGITS-1:0] digits_in,
    input  logic [DIGITS-1:0]         dp_in,
    input  logic [DIGITS-1:0]         blank_in,
    input  logic [DIGITS-1:0]         blink_mask,
    input  logic                      load,
    output logic [SEG_W-1:0]          segments,
    output logic                      DP,
    output logic [DIGITS-1:0]         anode_active,
    output logic                      frame_done
);

    localparam int unsigned IDX_W = idx_width(DIGITS);
    localparam int unsigned PRE_W = pre_width(REFRESH_DIV);
    localparam int unsigned DW    = DIGIT_W * DIGITS;

    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
        $error("DIGITS must be in 1..8");
    end
    if (REFRESH_DIV < 2) begin : g_bad_refresh
        $error("REFRESH_DIV must be at least 2");
    end
    if (BLINK_HALF < 2) begin : g_bad_blink
        $error("BLINK_HALF must be at least 2");
    end

    // Scan timing
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             tick, boundary;

    assign tick     = (pre_q == PRE_W'(REFRESH_DIV - 1));
    assign boundary = tick && (idx_q == IDX_W'(DIGITS - 1));

    always_comb begin
        pre_d = tick ? '0 : pre_q + 1'b1;
        idx_d = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= '0;
            idx_q <= '0;
        end else begin
            pre_q <= pre_d;
            idx_q <= idx_d;
        end
    end

    // Double buffer
    logic [DW-1:0]     pend_digits_q, pend_digits_d, act_digits_q, act_digits_d;
    logic [DIGITS-1:0] pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
    logic [DIGITS-1:0] pend_blank_q, pend_blank_d, act_blank_q, act_blank_d;
    logic              pend_valid_q, pend_valid_d;
`ifdef SEVEN_SEG_BLINK_EN
    logic [DIGITS-1:0] pend_blink_q, pend_blink_d, act_blink_q, act_blink_d;
`endif

    always_comb begin
        pend_digits_d = pend_digits_q;
        pend_dp_d     = pend_dp_q;
        pend_blank_d  = pend_blank_q;
        pend_valid_d  = pend_valid_q;
        act_digits_d  = act_digits_q;
        act_dp_d      = act_dp_q;
        act_blank_d   = act_blank_q;
`ifdef SEVEN_SEG_BLINK_EN
        pend_blink_d  = pend_blink_q;
        act_blink_d   = act_blink_q;
`endif
        if (load) begin
            pend_digits_d = digits_in;
            pend_dp_d     = dp_in;
            pend_blank_d  = blank_in;
            pend_valid_d  = 1'b1;
`ifdef SEVEN_SEG_BLINK_EN
            pend_blink_d  = blink_mask;
`endif
        end
        // A load landing on the boundary bypasses pending straight into active.
        if (boundary) begin
            if (load) begin
                act_digits_d = digits_in;
                act_dp_d     = dp_in;
                act_blank_d  = blank_in;
                pend_valid_d = 1'b0;
`ifdef SEVEN_SEG_BLINK_EN
                act_blink_d  = blink_mask;
`endif
            end else if (pend_valid_q) begin
                act_digits_d = pend_digits_q;
                act_dp_d     = pend_dp_q;
                act_blank_d  = pend_blank_q;
                pend_valid_d = 1'b0;
`ifdef SEVEN_SEG_BLINK_EN
                act_blink_d  = pend_blink_q;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_digits_q <= '0;
            pend_dp_q     <= '0;
            pend_blank_q  <= '1;
            pend_valid_q  <= 1'b0;
            act_digits_q  <= '0;
            act_dp_q      <= '0;
            act_blank_q   <= '1;
`ifdef SEVEN_SEG_BLINK_EN
            pend_blink_q  <= '0;
            act_blink_q   <= '0;
`endif
        end else begin
            pend_digits_q <= pend_digits_d;
            pend_dp_q     <= pend_dp_d;
            pend_blank_q  <= pend_blank_d;
            pend_valid_q  <= pend_valid_d;
            act_digits_q  <= act_digits_d;
            act_dp_q      <= act_dp_d;
            act_blank_q   <= act_blank_d;
`ifdef SEVEN_SEG_BLINK_EN
            pend_blink_q  <= pend_blink_d;
            act_blink_q   <= act_blink_d;
`endif
        end
    end

    // Blink phase
    logic dark;
`ifdef SEVEN_SEG_BLINK_EN
    localparam int unsigned BLK_W = pre_width(BLINK_HALF);

    logic [BLK_W-1:0] blink_cnt_q;
    logic             blink_tick, phase_q, phase_d;

    assign blink_tick = (blink_cnt_q == BLK_W'(BLINK_HALF - 1));
    assign phase_d    = phase_q ^ blink_tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_tick ? '0 : blink_cnt_q + 1'b1;
            phase_q     <= phase_d;
        end
    end

    assign dark = act_blank_d[idx_d] | (act_blink_d[idx_d] & phase_d);
`else
    logic unused_blink_mask;
    assign unused_blink_mask = ^blink_mask;
    assign dark = act_blank_d[idx_d];
`endif

    // Outputs are built from next-state values so anode and segments move on the same edge.
    logic [DIGIT_W-1:0] sel_hex;
    logic [SEG_W-1:0]   sel_seg;

    assign sel_hex = act_digits_d[DIGIT_W*idx_d +: DIGIT_W];

    seven_seg_hex_decoder u_dec (
        .hex (sel_hex),
        .seg (sel_seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            segments     <= SEG_BLANK;
            DP           <= 1'b1;
            anode_active <= '1;
            frame_done   <= 1'b0;
        end else begin
            segments     <= dark ? SEG_BLANK : sel_seg;
            DP           <= dark | ~act_dp_d[idx_d];
            anode_active <= ~(DIGITS'(1) << idx_d);
            frame_done   <= boundary;
        end
    end

endmodule

// File: tb/tb_seven_seg_mux_n.sv
// Self-checking bench for seven_seg_mux_n: cycle-count reference model plus directed and random
// stimulus. Honours SEVEN_SEG_BLINK_EN when defined.
module tb_seven_seg_mux_n;

    localparam int unsigned D     = 4;
    localparam int unsigned R     = 4;
    localparam int unsigned H     = 8;
    localparam int unsigned FRAME = D * R;
`ifdef SEVEN_SEG_BLINK_EN
    localparam bit BLINK_EN = 1'b1;
`else
    localparam bit BLINK_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [4*D-1:0] digits_in = '0;
    logic [D-1:0]   dp_in = '0;
    logic [D-1:0]   blank_in = '0;
    logic [D-1:0]   blink_mask = '0;
    logic           load = 1'b0;
    logic [6:0]     segments;
    logic           DP;
    logic [D-1:0]   anode_active;
    logic           frame_done;

    seven_seg_mux_n #(
        .DIGITS      (D),
        .REFRESH_DIV (R),
        .BLINK_HALF  (H)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .digits_in    (digits_in),
        .dp_in        (dp_in),
        .blank_in     (blank_in),
        .blink_mask   (blink_mask),
        .load         (load),
        .segments     (segments),
        .DP           (DP),
        .anode_active (anode_active),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, req, $time);
        end
    endtask

    // Active-low {g,f,e,d,c,b,a} for hex 0..F
    logic [6:0] hex_pat [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model: state is a pure function of cycles since reset, plus the two banks.
    bit             model_ok = 1'b0;
    int unsigned    t = 0;
    logic [4*D-1:0] m_pd, m_ad;
    logic [D-1:0]   m_pdp, m_adp, m_pbl, m_abl, m_pbk, m_abk;
    bit             m_pv;
    logic [6:0]     e_seg;
    logic           e_dp, e_fd;
    logic [D-1:0]   e_an;

    initial begin
        int unsigned idx;
        bit          phase, dark;
        forever begin
            @(posedge clk);
            if (rst) begin
                model_ok = 1'b1;
                t = 0;
                m_pd = '0; m_pdp = '0; m_pbl = '1; m_pbk = '0; m_pv = 1'b0;
                m_ad = '0; m_adp = '0; m_abl = '1; m_abk = '0;
                e_seg = 7'h7F; e_dp = 1'b1; e_an = '1; e_fd = 1'b0;
            end else begin
                t++;
                if (load) begin
                    m_pd = digits_in; m_pdp = dp_in; m_pbl = blank_in; m_pbk = blink_mask;
                    m_pv = 1'b1;
                end
                if (t % FRAME == 0 && m_pv) begin
                    m_ad = m_pd; m_adp = m_pdp; m_abl = m_pbl; m_abk = m_pbk;
                    m_pv = 1'b0;
                end
                idx   = (t / R) % D;
                phase = BLINK_EN && ((t / H) % 2 == 1);
                dark  = m_abl[idx] || (m_abk[idx] && phase);
                e_seg = dark ? 7'h7F : hex_pat[m_ad[idx*4 +: 4]];
                e_dp  = dark ? 1'b1 : ~m_adp[idx];
                e_an  = ~(D'(1) << idx);
                e_fd  = (t % FRAME == 0);
            end
        end
    end

    // Every-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (model_ok) begin
                check("segments", 32'(segments), 32'(e_seg));
                check("dp", 32'(DP), 32'(e_dp));
                check("anode", 32'(anode_active), 32'(e_an));
                check("frame_done", 32'(frame_done), 32'(e_fd));
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [4*D-1:0] dg, input logic [D-1:0] dp,
                           input logic [D-1:0] bl, input logic [D-1:0] bk);
        digits_in = dg; dp_in = dp; blank_in = bl; blink_mask = bk;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_frame();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 3 * FRAME);
        check("frame_done_timeout", 32'(frame_done), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        cycles(3);
        check("rst_segments", 32'(segments), 32'h7F);
        check("rst_anode", 32'(anode_active), 32'hF);
        check("rst_dp", 32'(DP), 32'd1);
        rst = 1'b0;
        cycles(1);
        check("first_anode", 32'(anode_active), 32'hE);
        check("first_dark", 32'(segments), 32'h7F);

        // Scan order 0,1,2,3
        do_load(16'h3210, 4'b0000, 4'b0000, 4'b0000);
        wait_frame();
        check("d0_anode", 32'(anode_active), 32'hE);
        check("d0_seg", 32'(segments), 32'h40);
        cycles(1);
        check("fd_low", 32'(frame_done), 32'd0);
        cycles(3);
        check("d1_anode", 32'(anode_active), 32'hD);
        check("d1_seg", 32'(segments), 32'h79);
        cycles(4);
        check("d2_anode", 32'(anode_active), 32'hB);
        check("d2_seg", 32'(segments), 32'h24);
        cycles(4);
        check("d3_anode", 32'(anode_active), 32'h7);
        check("d3_seg", 32'(segments), 32'h30);
        cycles(4);
        check("fd_period", 32'(frame_done), 32'd1);

        // Two loads in one frame: the last one wins at the next boundary
        cycles(1);
        do_load(16'hABCD, 4'b0000, 4'b0000, 4'b0000);
        cycles(7);
        do_load(16'h1234, 4'b0000, 4'b0000, 4'b0000);
        wait_frame();
        check("last_load_wins", 32'(segments), 32'(hex_pat[4]));
        cycles(2 * FRAME);

        // Load coincident with the frame boundary
        wait_frame();
        cycles(FRAME - 1);
        do_load(16'h5A5A, 4'b0000, 4'b0000, 4'b0000);
        check("bypass_fd", 32'(frame_done), 32'd1);
        check("bypass_seg", 32'(segments), 32'h08);
        cycles(FRAME);

        // Blink on digit 1
        do_load(16'h8888, 4'b0000, 4'b0000, 4'b0010);
        wait_frame();
        cycles(4 * FRAME);

        // Decimal point on digit 2, digit 3 blanked
        do_load(16'h7654, 4'b0100, 4'b1000, 4'b0000);
        wait_frame();
        check("dp_d0", 32'(DP), 32'd1);
        cycles(8);
        check("dp_d2_anode", 32'(anode_active), 32'hB);
        check("dp_d2", 32'(DP), 32'd0);
        cycles(4);
        check("blank_d3_seg", 32'(segments), 32'h7F);
        check("blank_d3_dp", 32'(DP), 32'd1);

        // Reset with a load pending
        cycles(5);
        do_load(16'hFFFF, 4'b1111, 4'b0000, 4'b0000);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        check("rstmid_seg", 32'(segments), 32'h7F);
        check("rstmid_anode", 32'(anode_active), 32'hF);
        check("rstmid_fd", 32'(frame_done), 32'd0);
        cycles(2 * FRAME + 3);
        check("rstmid_dark", 32'(segments), 32'h7F);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            digits_in  = 16'($urandom);
            dp_in      = 4'($urandom);
            blank_in   = 4'($urandom) & 4'($urandom);
            blink_mask = 4'($urandom);
            load       = ($urandom_range(0, 9) == 0);
            rst        = ($urandom_range(0, 199) == 0);
            @(negedge clk);
        end
        load = 1'b0;
        rst  = 1'b0;
        cycles(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
